// File: rtl/des_blk_ctrl_if.sv
// 32-bit valid/ready word stream used for both the plaintext input and result output.
interface des_blk_ctrl_if;
   localparam int unsigned DATA_W = 32;

   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/des_blk_ctrl.sv
// Host-side block sequencer for the DES round core: packs two input words into a
// block, fires the core once, applies optional CBC chaining and streams the result back.
module des_blk_ctrl #(
   parameter int unsigned TIMEOUT = 20
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        encrypt,
   input  logic [1:0]  edr,
   input  logic        cbc_en,
   input  logic [63:0] key_in,
   input  logic [63:0] iv,
   input  logic        iv_load,
   des_blk_ctrl_if.slave  in_s,
   des_blk_ctrl_if.master out_s,
   output logic        core_encrypt,
   output logic [1:0]  core_edr,
   output logic [63:0] core_key,
   output logic [63:0] core_din,
   output logic        core_din_valid,
   input  logic [63:0] core_dout,
   input  logic        core_dout_valid,
   output logic        busy,
   output logic        timeout_err
);
   localparam int unsigned BLK_W = 64;
   localparam int unsigned WRD_W = 32;
   localparam int unsigned CNT_W = 8;
   // Last WAIT cycle that still accepts a core answer; the error flag shows TIMEOUT cycles after FIRE.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

   typedef enum logic [2:0] {
      S_IDLE, S_GET_LO, S_FIRE, S_WAIT, S_OUT_HI, S_OUT_LO
   } state_t;

   state_t             state_q, state_d;
   logic [BLK_W-1:0]   blk_q, blk_d;
   logic [BLK_W-1:0]   res_q, res_d;
   logic [BLK_W-1:0]   chain_q, chain_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cbc_q, cbc_d;
   logic               core_encrypt_q, core_encrypt_d;
   logic [1:0]         core_edr_q, core_edr_d;
   logic [BLK_W-1:0]   core_key_q, core_key_d;
   logic [BLK_W-1:0]   core_din_q, core_din_d;
   logic               core_din_valid_q, core_din_valid_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [WRD_W-1:0]   out_data_q, out_data_d;
   logic               busy_q, busy_d;
   logic               timeout_err_q, timeout_err_d;
   logic               in_hs, out_hs;

   assign in_hs  = in_s.valid & in_ready_q;
   assign out_hs = out_valid_q & out_s.ready;

   // State register and all registered outputs.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q          <= S_IDLE;
         blk_q            <= '0;
         res_q            <= '0;
         chain_q          <= '0;
         cnt_q            <= '0;
         cbc_q            <= 1'b0;
         core_encrypt_q   <= 1'b0;
         core_edr_q       <= '0;
         core_key_q       <= '0;
         core_din_q       <= '0;
         core_din_valid_q <= 1'b0;
         in_ready_q       <= 1'b1;
         out_valid_q      <= 1'b0;
         out_data_q       <= '0;
         busy_q           <= 1'b0;
         timeout_err_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         blk_q            <= blk_d;
         res_q            <= res_d;
         chain_q          <= chain_d;
         cnt_q            <= cnt_d;
         cbc_q            <= cbc_d;
         core_encrypt_q   <= core_encrypt_d;
         core_edr_q       <= core_edr_d;
         core_key_q       <= core_key_d;
         core_din_q       <= core_din_d;
         core_din_valid_q <= core_din_valid_d;
         in_ready_q       <= in_ready_d;
         out_valid_q      <= out_valid_d;
         out_data_q       <= out_data_d;
         busy_q           <= busy_d;
         timeout_err_q    <= timeout_err_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d        = state_q;
      blk_d          = blk_q;
      res_d          = res_q;
      chain_d        = chain_q;
      cnt_d          = cnt_q;
      cbc_d          = cbc_q;
      core_encrypt_d = core_encrypt_q;
      core_edr_d     = core_edr_q;
      core_key_d     = core_key_q;
      core_din_d     = core_din_q;
      out_data_d     = out_data_q;
      timeout_err_d  = timeout_err_q;

      case (state_q)
         S_IDLE: begin
            if (iv_load) begin
               chain_d       = iv;
               timeout_err_d = 1'b0;
            end
            if (in_hs) begin
               blk_d[63:32]   = in_s.data;
               core_encrypt_d = encrypt;
               core_edr_d     = edr;
               cbc_d          = cbc_en;
               core_key_d     = key_in;
               state_d        = S_GET_LO;
            end
         end
         S_GET_LO: begin
            if (in_hs) begin
               blk_d[31:0] = in_s.data;
               core_din_d  = (cbc_q & core_encrypt_q) ? (blk_d ^ chain_q) : blk_d;
               state_d     = S_FIRE;
            end
         end
         S_FIRE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (core_dout_valid) begin
               res_d = (cbc_q & ~core_encrypt_q) ? (core_dout ^ chain_q) : core_dout;
               if (cbc_q) begin
                  chain_d = core_encrypt_q ? core_dout : blk_q;
               end
               out_data_d = res_d[63:32];
               state_d    = S_OUT_HI;
            end else if (cnt_q == CNT_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_OUT_HI: begin
            if (out_hs) begin
               out_data_d = res_q[31:0];
               state_d    = S_OUT_LO;
            end
         end
         S_OUT_LO: begin
            if (out_hs) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d       = (state_d == S_IDLE) || (state_d == S_GET_LO);
      out_valid_d      = (state_d == S_OUT_HI) || (state_d == S_OUT_LO);
      core_din_valid_d = (state_d == S_FIRE);
      busy_d           = (state_d != S_IDLE);
   end

   assign in_s.ready     = in_ready_q;
   assign out_s.valid    = out_valid_q;
   assign out_s.data     = out_data_q;
   assign core_encrypt   = core_encrypt_q;
   assign core_edr       = core_edr_q;
   assign core_key       = core_key_q;
   assign core_din       = core_din_q;
   assign core_din_valid = core_din_valid_q;
   assign busy           = busy_q;
   assign timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_des_blk_ctrl.sv
// Directed bench for des_blk_ctrl: a block-level model predicts core_din and result words,
// a stub stands in for the DES core, and one negedge process compares against the model.
module tb_des_blk_ctrl;
   localparam int unsigned TIMEOUT = 20;

   logic        hclk;
   logic        hresetn;
   logic        encrypt;
   logic [1:0]  edr;
   logic        cbc_en;
   logic [63:0] key_in;
   logic [63:0] iv;
   logic        iv_load;
   logic        core_encrypt;
   logic [1:0]  core_edr;
   logic [63:0] core_key;
   logic [63:0] core_din;
   logic        core_din_valid;
   logic [63:0] core_dout;
   logic        core_dout_valid;
   logic        busy;
   logic        timeout_err;

   des_blk_ctrl_if in_if();
   des_blk_ctrl_if out_if();

   des_blk_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .hclk(hclk), .hresetn(hresetn), .encrypt(encrypt), .edr(edr), .cbc_en(cbc_en),
      .key_in(key_in), .iv(iv), .iv_load(iv_load), .in_s(in_if.slave), .out_s(out_if.master),
      .core_encrypt(core_encrypt), .core_edr(core_edr), .core_key(core_key),
      .core_din(core_din), .core_din_valid(core_din_valid), .core_dout(core_dout),
      .core_dout_valid(core_dout_valid), .busy(busy), .timeout_err(timeout_err)
   );

   typedef struct packed {
      logic [63:0] din;
      logic [63:0] key;
      logic        enc;
      logic [1:0]  edr;
   } din_exp_t;

   din_exp_t    exp_din[$];
   logic [31:0] exp_out[$];
   logic [31:0] got_out[$];
   logic [63:0] got_din[$];
   logic [63:0] m_chain;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int dv_cnt = 0;
   int hs_cyc = 0;
   int ov_cyc = 0;
   int fire_cyc = 0;
   logic        ov_prev = 1'b0;
   logic        stall_prev = 1'b0;
   logic [31:0] data_prev = '0;

   bit          core_mute = 1'b0;
   bit          core_fixed_en = 1'b0;
   logic [63:0] core_fixed = '0;
   int          core_lat = 1;

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;
   always @(posedge hclk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   function automatic logic [63:0] core_fn(input logic [63:0] x);
      return {x[31:0], x[63:32]} ^ 64'hA5A5_5A5A_0F0F_F0F0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Stand-in for the DES core: answers core_lat cycles after it sees din_valid.
   initial begin
      logic [63:0] d;
      core_dout_valid = 1'b0;
      core_dout = '0;
      forever begin
         @(negedge hclk);
         if (hresetn && core_din_valid && !core_mute) begin
            d = core_din;
            repeat (core_lat) @(posedge hclk);
            #1;
            core_dout = core_fixed_en ? core_fixed : core_fn(d);
            core_dout_valid = 1'b1;
            @(posedge hclk);
            #1 core_dout_valid = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model queues.
   always @(negedge hclk) begin
      if (hresetn) begin
         if (core_din_valid) begin
            dv_cnt++;
            fire_cyc = cyc;
            got_din.push_back(core_din);
            checks++;
            if (exp_din.size() == 0) begin
               errors++;
               $display("FAIL din_valid: got unexpected pulse din=%h expected none", core_din);
            end else begin
               din_exp_t e;
               e = exp_din.pop_front();
               check("core_din", core_din, e.din);
               check("core_key", core_key, e.key);
               check("core_encrypt", 64'(core_encrypt), 64'(e.enc));
               check("core_edr", 64'(core_edr), 64'(e.edr));
            end
         end
         if (out_if.valid && !ov_prev) ov_cyc = cyc;
         if (stall_prev) begin
            check("stall_valid", 64'(out_if.valid), 64'(1));
            check("stall_data", 64'(out_if.data), 64'(data_prev));
         end
         if (out_if.valid && out_if.ready) begin
            got_out.push_back(out_if.data);
            checks++;
            if (exp_out.size() == 0) begin
               errors++;
               $display("FAIL out_word: got unexpected word %h expected none", out_if.data);
            end else begin
               logic [31:0] w;
               w = exp_out.pop_front();
               checks--;
               check("out_data", 64'(out_if.data), 64'(w));
            end
         end
         ov_prev    = out_if.valid;
         stall_prev = out_if.valid && !out_if.ready;
         data_prev  = out_if.data;
      end else begin
         ov_prev    = 1'b0;
         stall_prev = 1'b0;
      end
   end

   task automatic send_word(input logic [31:0] w);
      int n = 0;
      @(posedge hclk);
      #1;
      in_if.valid = 1'b1;
      in_if.data  = w;
      @(negedge hclk);
      while (!in_if.ready && n < 200) begin
         @(negedge hclk);
         n++;
      end
      if (!in_if.ready) begin
         checks++;
         errors++;
         $display("FAIL send_word: got in_ready=0 expected 1 within 200 cycles");
      end
      hs_cyc = cyc;
      @(posedge hclk);
      #1 in_if.valid = 1'b0;
   endtask

   // Predict one block from the block-level rules, then drive it; mid-block input changes are garbage.
   task automatic run_block(input logic [63:0] blk, input logic enc, input logic [1:0] e,
                            input logic cbc, input logic [63:0] key, input bit responds);
      din_exp_t    x;
      logic [63:0] dout, res;
      x.din = (cbc && enc) ? (blk ^ m_chain) : blk;
      x.key = key;
      x.enc = enc;
      x.edr = e;
      exp_din.push_back(x);
      if (responds) begin
         dout = core_fixed_en ? core_fixed : core_fn(x.din);
         res  = (cbc && !enc) ? (dout ^ m_chain) : dout;
         if (cbc) m_chain = enc ? dout : blk;
         exp_out.push_back(res[63:32]);
         exp_out.push_back(res[31:0]);
      end
      encrypt = enc;
      edr     = e;
      cbc_en  = cbc;
      key_in  = key;
      send_word(blk[63:32]);
      encrypt = ~enc;
      edr     = ~e;
      cbc_en  = ~cbc;
      key_in  = ~key;
      send_word(blk[31:0]);
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge hclk);
      #1;
      while (!(exp_out.size() == 0 && in_if.ready && !busy) && n < 500) begin
         @(negedge hclk);
         #1;
         n++;
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL wait_done: got busy=%0b pending=%0d expected idle", busy, exp_out.size());
      end
   endtask

   task automatic wait_fire(input int dv0);
      int n = 0;
      while (dv_cnt == dv0 && n < 50) begin
         @(negedge hclk);
         #1;
         n++;
      end
      if (dv_cnt == dv0) begin
         checks++;
         errors++;
         $display("FAIL wait_fire: got no din_valid expected one within 50 cycles");
      end
   endtask

   task automatic load_iv(input logic [63:0] v);
      @(posedge hclk);
      #1;
      iv      = v;
      iv_load = 1'b1;
      @(posedge hclk);
      #1 iv_load = 1'b0;
      m_chain = v;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"}, 64'(in_if.ready), 64'(1));
      check({tag, "_out_valid"}, 64'(out_if.valid), 64'(0));
      check({tag, "_out_data"}, 64'(out_if.data), 64'(0));
      check({tag, "_din_valid"}, 64'(core_din_valid), 64'(0));
      check({tag, "_core_din"}, core_din, 64'(0));
      check({tag, "_core_key"}, core_key, 64'(0));
      check({tag, "_core_enc"}, 64'(core_encrypt), 64'(0));
      check({tag, "_core_edr"}, 64'(core_edr), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
   endtask

   initial begin
      int dv0;
      hresetn = 1'b0;
      encrypt = 1'b0; edr = 2'b00; cbc_en = 1'b0; key_in = '0;
      iv = '0; iv_load = 1'b0;
      in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b1;
      m_chain = '0;
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      check_reset("rst");
      hresetn = 1'b1;

      // ECB encrypt with the textbook key/plaintext pair
      core_fixed_en = 1'b1; core_fixed = 64'h85E8_1354_0F0A_B405; core_lat = 16;
      dv0 = dv_cnt; got_out.delete();
      run_block(64'h0123_4567_89AB_CDEF, 1'b1, 2'b00, 1'b0, 64'h1334_5779_9BBC_DFF1, 1'b1);
      wait_done();
      check("t1_din_valid_cycles", 64'(dv_cnt - dv0), 64'(1));
      check("t1_word_hi", 64'(got_out[0]), 64'h85E8_1354);
      check("t1_word_lo", 64'(got_out[1]), 64'h0F0A_B405);

      // CBC encrypt chaining over three zero blocks
      core_fixed_en = 1'b0; core_lat = 3;
      load_iv(64'h1);
      got_din.delete();
      for (int i = 0; i < 3; i++) begin
         run_block(64'h0, 1'b1, 2'b00, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b1);
         wait_done();
      end
      check("t2_first_din", got_din[0], 64'h1);
      check("t2_second_din", got_din[1], core_fn(64'h1));
      check("t2_chain_after", got_din[2], core_fn(core_fn(64'h1)));

      // CBC decrypt: result xor chain, chain takes the ciphertext
      load_iv(64'hFFFF_FFFF_FFFF_FFFF);
      core_fixed_en = 1'b1; core_fixed = 64'h1; core_lat = 5;
      got_out.delete();
      run_block(64'h0123_4567_89AB_CDEF, 1'b0, 2'b10, 1'b1, 64'h0F1E_2D3C_4B5A_6978, 1'b1);
      wait_done();
      check("t3_res", {got_out[0], got_out[1]}, 64'hFFFF_FFFF_FFFF_FFFE);
      core_fixed = 64'h0;
      run_block(64'h1111_2222_3333_4444, 1'b0, 2'b11, 1'b1, 64'h0F1E_2D3C_4B5A_6978, 1'b1);
      wait_done();
      check("t3_chain_ct", {got_out[2], got_out[3]}, 64'h0123_4567_89AB_CDEF);

      // Output stall: data stable, input blocked
      core_fixed_en = 1'b0; core_lat = 2;
      out_if.ready = 1'b0;
      run_block(64'hCAFE_F00D_1234_5678, 1'b1, 2'b00, 1'b0, 64'h5555_AAAA_5555_AAAA, 1'b1);
      begin
         int n = 0;
         while (!out_if.valid && n < 100) begin
            @(negedge hclk);
            n++;
         end
      end
      in_if.valid = 1'b1; in_if.data = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         @(negedge hclk);
         check("t4_out_valid", 64'(out_if.valid), 64'(1));
         check("t4_out_data", 64'(out_if.data), 64'(exp_out[0]));
         check("t4_in_ready", 64'(in_if.ready), 64'(0));
      end
      @(posedge hclk);
      #1;
      in_if.valid = 1'b0;
      out_if.ready = 1'b1;
      wait_done();
      check("t4_idle_busy", 64'(busy), 64'(0));

      // Core never answers: timeout
      core_mute = 1'b1;
      dv0 = dv_cnt;
      run_block(64'h0BAD_0BAD_0BAD_0BAD, 1'b1, 2'b00, 1'b0, 64'h1, 1'b0);
      wait_fire(dv0);
      repeat (TIMEOUT - 1) @(negedge hclk);
      check("t5_err_early", 64'(timeout_err), 64'(0));
      @(negedge hclk);
      check("t5_err_set", 64'(timeout_err), 64'(1));
      check("t5_in_ready", 64'(in_if.ready), 64'(1));
      check("t5_busy", 64'(busy), 64'(0));
      load_iv(64'h0);
      @(negedge hclk);
      check("t5_err_cleared", 64'(timeout_err), 64'(0));
      core_mute = 1'b0;

      // Reset three cycles into WAIT, core answers after release
      core_fixed_en = 1'b1; core_fixed = 64'h7777_8888_9999_AAAA; core_lat = 10;
      dv0 = dv_cnt;
      run_block(64'h2468_ACE0_1357_9BDF, 1'b1, 2'b01, 1'b0, 64'h3C3C_3C3C_3C3C_3C3C, 1'b1);
      wait_fire(dv0);
      repeat (3) @(negedge hclk);
      hresetn = 1'b0;
      #1;
      check_reset("t6");
      exp_din.delete(); exp_out.delete(); m_chain = '0;
      @(negedge hclk);
      hresetn = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge hclk);
         check("t6_out_valid", 64'(out_if.valid), 64'(0));
         check("t6_busy", 64'(busy), 64'(0));
      end

      // Bypass core latency
      core_fixed = 64'h0102_0304_0506_0708; core_lat = 1;
      run_block(64'h0, 1'b0, 2'b01, 1'b0, 64'h9, 1'b1);
      wait_done();
      check("t7_latency", 64'(ov_cyc - hs_cyc), 64'(3));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/des_blk_ctrl.md
Name: des_blk_ctrl

Overview:
Host-side sequencer for the DES round core. Accepts 32-bit plaintext/ciphertext words on a valid/ready stream and assembles them into 64-bit blocks. Issues one single-cycle din_valid per block, holds the core's static inputs stable while it is busy, and captures dout on dout_valid. Applies optional CBC chaining and returns the result as two 32-bit words on an output valid/ready stream.

Parameters:
TIMEOUT, 20, cycles to wait for core_dout_valid after core_din_valid before aborting the block (range 2..255).

Ports:
hclk  input  1  system clock, rising edge
hresetn  input  1  asynchronous active-low reset
encrypt  input  1  1=encrypt, 0=decrypt; sampled at block start
edr  input  2  core pass-count select; sampled at block start
cbc_en  input  1  1=CBC, 0=ECB; sampled at block start
key_in  input  64  key; sampled at block start
iv  input  64  CBC initial vector
iv_load  input  1  pulse: chain register <= iv (ignored unless IDLE)
in_valid  input  1  input word valid
in_ready  output  1  controller can accept input word
in_data  input  32  input word; first word = bits 63:32
out_valid  output  1  output word valid
out_ready  input  1  consumer accepts output word
out_data  output  32  output word; first word = bits 63:32
core_encrypt  output  1  to core encrypt
core_edr  output  2  to core edr
core_key  output  64  to core key_in
core_din  output  64  to core din
core_din_valid  output  1  to core din_valid
core_dout  input  64  from core dout
core_dout_valid  input  1  from core dout_valid
busy  output  1  high in any state except IDLE
timeout_err  output  1  sticky; cleared by iv_load or reset

Behaviour:
- Reset values: state IDLE; in_ready=1; out_valid=0; out_data=0; core_din_valid=0; core_din=0; core_key=0; core_encrypt=0; core_edr=0; chain=0; busy=0; timeout_err=0.
- A transfer occurs on any cycle where valid and ready are both 1. Data, valid, and ready are all registered outputs.
- States:
  - IDLE: in_ready=1. A handshake stores the word into blk_in[63:32], latches encrypt/edr/cbc_en/key_in onto the core_* outputs, and moves to GET_LO.
  - GET_LO: in_ready=1. A handshake stores the word into blk_in[31:0] and moves to FIRE.
  - FIRE: one cycle. core_din_valid=1 for exactly this cycle.
    - core_din = blk_in ^ chain when cbc_en & encrypt; otherwise blk_in.
    - Timeout counter cleared. Next state WAIT.
  - WAIT: in_ready=0. Counter increments each cycle.
    - On core_dout_valid: capture res = core_dout, XORed with chain when cbc_en & ~encrypt.
    - In the same cycle, when cbc_en: chain <= core_dout if encrypt, else chain <= blk_in.
    - Then go to OUT_HI.
    - If the counter reaches TIMEOUT first: set timeout_err, drop the block, return to IDLE, leave chain unchanged.
  - OUT_HI: out_valid=1, out_data=res[63:32]. On handshake go to OUT_LO.
  - OUT_LO: out_valid=1, out_data=res[31:0]. On handshake go to IDLE; in_ready rises the next cycle.
- core_encrypt/core_edr/core_key are held constant from the first-word handshake until return to IDLE. Mid-block changes on encrypt/edr/key_in/cbc_en have no effect.
- core_din_valid is never asserted outside FIRE. A core_dout_valid arriving outside WAIT is ignored.
- edr=01 (core bypass): core answers the cycle after din_valid. Block latency from second-word handshake to out_valid = 3 cycles.
- Other edr: latency follows the core round count. The controller makes no assumption beyond TIMEOUT.
- out_valid holds while out_ready=0; out_data is stable during the stall. No new input is accepted until both output words are taken, so there is no overlap.
- iv_load in IDLE loads chain and clears timeout_err. iv_load in any other state is ignored.
- hresetn low at any time returns everything to reset values immediately, including mid-WAIT. A core_dout_valid arriving after reset is released is ignored.

Test Plan:
1. ECB encrypt, edr=00, key 0x133457799BBCDFF1, words 0x01234567 then 0x89ABCDEF, core model returning 0x85E813540F0AB405 after 16 cycles -> out words 0x85E81354 then 0x0F0AB405; core_din_valid high exactly 1 cycle.
2. CBC encrypt, iv=0x0000000000000001 loaded, two blocks of 0x0 -> first core_din=0x1; second core_din = first core_dout; chain = second core_dout afterwards.
3. CBC decrypt, chain=0xFFFFFFFFFFFFFFFF, core_dout=0x1 -> res=0xFFFFFFFFFFFFFFFE; chain <= ciphertext input block.
4. out_ready held 0 for 5 cycles in OUT_HI -> out_valid=1, out_data stable, in_ready=0 throughout; input pushed meanwhile not accepted.
5. Core never asserts dout_valid, TIMEOUT=20 -> timeout_err=1 twenty cycles after FIRE, state IDLE, in_ready=1; iv_load clears timeout_err.
6. Reset asserted 3 cycles into WAIT, late core_dout_valid after release -> all outputs at reset values, out_valid stays 0.
